// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, instruction-queue geometry and the queue entry type
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int IQ_SIZE_BIT = 4;
    localparam int DEPTH       = 1 << IQ_SIZE_BIT;
    localparam int AF_MARGIN   = 2;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
    } iq_entry_t;

endpackage

// File: rtl/circular_fifo_ctrl.sv
// circular_fifo_ctrl: head/tail/count bookkeeping and full flags for a power-of-two ring buffer
module circular_fifo_ctrl #(
    parameter int SIZE_BIT  = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic                pop_i,
    output logic                enq_o,
    output logic                deq_o,
    output logic [SIZE_BIT-1:0] head_o,
    output logic [SIZE_BIT-1:0] tail_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                almost_full_o
);

    localparam int CW    = SIZE_BIT + 1;
    localparam int DEPTH = 1 << SIZE_BIT;

    logic [SIZE_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;

    assign empty_o       = count_q == '0;
    assign full_o        = count_q == CW'(DEPTH);
    assign almost_full_o = count_q >= CW'(DEPTH - AF_MARGIN);
    assign enq_o         = push_i && !full_o && rdy_in && !flush_i;
    assign deq_o         = pop_i && !empty_o && rdy_in && !flush_i;
    assign head_o        = head_q;
    assign tail_o        = tail_q;

    // Advance pointers on accepted traffic; a flush drops everything back to empty
    always_comb begin
        head_d  = flush_i ? '0 : head_q + SIZE_BIT'(deq_o);
        tail_d  = flush_i ? '0 : tail_q + SIZE_BIT'(enq_o);
        count_d = flush_i ? '0 : count_q + CW'(enq_o) - CW'(deq_o);
    end

    // Pointer/count registers: reset dominates, rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: fetch-to-dispatch instruction FIFO; define IQ_BYPASS_EN for zero-latency empty-queue bypass
module instruction_queue
    import riscv_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_signal,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_pred_taken,
    output logic            iq_full,
    output logic            iq_almost_full,
    input  logic            dp_ready,
    output logic            iq_valid,
    output logic [XLEN-1:0] iq_inst,
    output logic [XLEN-1:0] iq_pc,
    output logic            iq_pred_taken
);

    iq_entry_t                mem_q [DEPTH];
    iq_entry_t                in_e, head_e;
    logic                     enq, deq, empty, push, bypass_hit;
    logic [IQ_SIZE_BIT-1:0]   head, tail;

    assign in_e = '{inst: if_inst, pc: if_pc, pred_taken: if_pred_taken};

`ifdef IQ_BYPASS_EN
    assign bypass_hit = empty && if_valid;
    assign push       = if_valid && !(bypass_hit && dp_ready);
`else
    assign bypass_hit = 1'b0;
    assign push       = if_valid;
`endif

    circular_fifo_ctrl #(
        .SIZE_BIT  (IQ_SIZE_BIT),
        .AF_MARGIN (AF_MARGIN)
    ) u_ctrl (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_i       (flush_signal),
        .push_i        (push),
        .pop_i         (dp_ready),
        .enq_o         (enq),
        .deq_o         (deq),
        .head_o        (head),
        .tail_o        (tail),
        .empty_o       (empty),
        .full_o        (iq_full),
        .almost_full_o (iq_almost_full)
    );

    // Head view: bypassed input, stored head entry, or zeros when nothing is valid
    always_comb begin
        head_e = bypass_hit ? in_e : (empty ? '0 : mem_q[head]);
    end

    assign iq_valid      = !empty || bypass_hit;
    assign iq_inst       = head_e.inst;
    assign iq_pc         = head_e.pc;
    assign iq_pred_taken = head_e.pred_taken;

    // Entry storage: written only on an accepted enqueue, contents need no reset
    always_ff @(posedge clk_in) begin
        if (enq) mem_q[tail] <= in_e;
    end

    logic unused_deq;
    assign unused_deq = deq;

endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: randomized and directed bench against a queue-based reference model
module tb_instruction_queue;
    import riscv_pkg::*;

`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic            rdy_in = 1'b1;
    logic            flush_signal = 1'b0;
    logic            if_valid = 1'b0;
    logic [XLEN-1:0] if_inst = '0;
    logic [XLEN-1:0] if_pc = '0;
    logic            if_pred_taken = 1'b0;
    logic            dp_ready = 1'b0;
    logic            iq_full, iq_almost_full, iq_valid, iq_pred_taken;
    logic [XLEN-1:0] iq_inst, iq_pc;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    iq_entry_t q[$];
    iq_entry_t exp_e;
    bit m_deq, m_enq, m_byp, exp_v;

    instruction_queue dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_signal   (flush_signal),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .iq_full        (iq_full),
        .iq_almost_full (iq_almost_full),
        .dp_ready       (dp_ready),
        .iq_valid       (iq_valid),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pred_taken  (iq_pred_taken)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc = pc;
        if_inst = $urandom;
        if_pred_taken = 1'($urandom);
        step();
        if_valid = 1'b0;
    endtask

    // Reference queue: what the FIFO must hold after each edge
    always @(posedge clk_in) begin
        if (!rst_in) begin
            q.delete();
            armed = 1'b1;
        end else if (rdy_in) begin
            if (flush_signal) q.delete();
            else begin
                m_byp = BYP && q.size() == 0 && if_valid && dp_ready;
                m_deq = q.size() != 0 && dp_ready;
                m_enq = if_valid && q.size() < DEPTH && !m_byp;
                if (m_deq) void'(q.pop_front());
                if (m_enq) q.push_back('{inst: if_inst, pc: if_pc, pred_taken: if_pred_taken});
            end
        end
    end

    // Every cycle: outputs must equal the reference head and occupancy flags
    always @(negedge clk_in) begin
        if (armed) begin
            exp_v = q.size() != 0 || (BYP && if_valid);
            exp_e = q.size() != 0 ? q[0] :
                    (BYP && if_valid) ? '{inst: if_inst, pc: if_pc, pred_taken: if_pred_taken} : '0;
            chk("cyc_valid", iq_valid, exp_v);
            chk("cyc_full", iq_full, q.size() == DEPTH);
            chk("cyc_afull", iq_almost_full, q.size() >= DEPTH - AF_MARGIN);
            chk("cyc_inst", iq_inst, exp_e.inst);
            chk("cyc_pc", iq_pc, exp_e.pc);
            chk("cyc_pred", iq_pred_taken, exp_e.pred_taken);
        end
    end

    initial begin
        int thr;
        if_valid = 1'b1;
        if_pc = 32'h100;
        if_inst = 32'h13;
        step();
        step();
        if_valid = 1'b0;
        #1;
        chk("rst_valid", iq_valid, 0);
        chk("rst_full", iq_full, 0);
        chk("rst_afull", iq_almost_full, 0);
        chk("rst_pc", iq_pc, 0);
        rst_in = 1'b1;
        if_valid = 1'b1;
        if_inst = 32'h00500093;
        if_pc = 32'h0;
        if_pred_taken = 1'b0;
        step();
        if_valid = 1'b0;
        chk("first_valid", iq_valid, 1);
        chk("first_inst", iq_inst, 32'h00500093);
        chk("first_pc", iq_pc, 0);
        chk("first_pred", iq_pred_taken, 0);
        flush_signal = 1'b1;
        step();
        flush_signal = 1'b0;
        chk("flush_clear", iq_valid, 0);

        for (int i = 0; i < 16; i++) begin
            push(32'(i * 4));
            if (i == 12) chk("afull_low", iq_almost_full, 0);
            if (i == 13) chk("afull_high", iq_almost_full, 1);
            if (i == 14) chk("full_low", iq_full, 0);
        end
        chk("full_high", iq_full, 1);
        push(32'hDEAD);
        chk("full_hold", iq_full, 1);
        dp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", iq_pc, 32'(i * 4));
            step();
        end
        dp_ready = 1'b0;
        chk("drained", iq_valid, 0);

        for (int i = 0; i < 15; i++) push(32'h1000 + 32'(i * 4));
        dp_ready = 1'b1;
        for (int i = 15; i < 35; i++) push(32'h1000 + 32'(i * 4));
        chk("wrap_afull", iq_almost_full, 1);
        chk("wrap_full", iq_full, 0);
        chk("wrap_head", iq_pc, 32'h1000 + 32'(20 * 4));
        for (int i = 0; i < 15; i++) step();
        dp_ready = 1'b0;
        chk("wrap_empty", iq_valid, 0);

        for (int i = 0; i < 8; i++) push(32'h2000 + 32'(i * 4));
        flush_signal = 1'b1;
        if_valid = 1'b1;
        dp_ready = 1'b1;
        step();
        flush_signal = 1'b0;
        if_valid = 1'b0;
        dp_ready = 1'b0;
        chk("flush_valid", iq_valid, 0);
        chk("flush_afull", iq_almost_full, 0);

        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i * 4));
        rdy_in = 1'b0;
        dp_ready = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h3F00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freeze_pc", iq_pc, 32'h3000);
        end
        rdy_in = 1'b1;
        if_valid = 1'b0;
        step();
        chk("resume_pc", iq_pc, 32'h3004);
        step();
        step();
        chk("resume_empty", iq_valid, 0);

        if_valid = 1'b1;
        if_pc = 32'h4000;
        #1;
        chk("byp_valid", iq_valid, BYP ? 1 : 0);
        step();
        if_valid = 1'b0;
        dp_ready = 1'b0;
        #1;
        chk("byp_after", iq_valid, BYP ? 0 : 1);
        flush_signal = 1'b1;
        step();
        flush_signal = 1'b0;

        thr = 50;
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 0) thr = (c / 150) % 2 == 0 ? 25 : 85;
            rst_in = ($urandom % 200) != 0;
            rdy_in = ($urandom % 8) != 0;
            flush_signal = ($urandom % 40) == 0;
            if_valid = ($urandom % 4) != 0;
            dp_ready = ($urandom % 100) < 32'(thr);
            if_inst = $urandom;
            if_pc = $urandom;
            if_pred_taken = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO of fetched instructions between the instruction fetcher and the Dispatcher.
- Decouples fetch bandwidth from dispatch stalls caused by a full RoB, LSB or RS.
- Holds the PC and branch-prediction bit with each instruction word.
- Supports a single-cycle flush on branch mispredict.

Parameters:
- IQ_SIZE_BIT, 4, log2 of entry count (DEPTH = 2^IQ_SIZE_BIT = 16).
- XLEN, 32, instruction and PC width.
- AF_MARGIN, 2, `iq_almost_full` asserts when count >= DEPTH - AF_MARGIN. Covers fetcher request latency.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global ready; 0 freezes all state.
- flush_signal  input  1  mispredict flush from RoB.
- if_valid  input  1  fetcher presents an instruction this cycle.
- if_inst  input  XLEN  instruction word.
- if_pc  input  XLEN  instruction PC.
- if_pred_taken  input  1  branch predictor decision.
- iq_full  output  1  count == DEPTH.
- iq_almost_full  output  1  see AF_MARGIN.
- dp_ready  input  1  Dispatcher accepts the head entry this cycle.
- iq_valid  output  1  head entry is valid.
- iq_inst  output  XLEN  head instruction word.
- iq_pc  output  XLEN  head PC.
- iq_pred_taken  output  1  head prediction bit.

Behaviour:
- State:
  - `head` and `tail`: IQ_SIZE_BIT-bit pointers that wrap modulo DEPTH.
  - `count`: IQ_SIZE_BIT+1 bits, range 0..DEPTH.
  - Entry arrays for inst, pc and pred.
- Reset (`rst_in` == 0 at a rising edge): `head`, `tail` and `count` go to 0.
  - All outputs then read 0: `iq_valid`, `iq_full`, `iq_almost_full`, `iq_inst`, `iq_pc`, `iq_pred_taken`.
  - Entry array contents are don't-care.
  - Reset wins over `rdy_in` and `flush_signal`.
- Freeze: when `rdy_in` == 0 and not in reset, no register changes. Outputs hold.
- Flush: `flush_signal` == 1 with `rdy_in` == 1 has the same effect as reset on the pointers and `count`.
  - Any enqueue or dequeue in that cycle is discarded.
- Enqueue (`enq`) = `if_valid` & !`iq_full` & `rdy_in` & !`flush_signal`.
  - Writes the entry at `tail`, then `tail` += 1.
  - If `if_valid` is high while full, the input is dropped. Protocol: the fetcher must stop on `iq_almost_full`.
- Dequeue (`deq`) = `iq_valid` & `dp_ready` & `rdy_in` & !`flush_signal`.
  - `head` += 1.
- Count update: +1 on enq only, -1 on deq only, unchanged when both occur.
  - Enq and deq are allowed together at any nonzero count, including DEPTH-1.
  - At count == DEPTH, enq is blocked even if a deq happens that cycle. The full flag is registered-count based; this is not pass-through.
- Outputs:
  - `iq_valid` = (`count` != 0).
  - Head fields are read combinationally from the entry at `head`.
  - `iq_full` and `iq_almost_full` are combinational from `count`.
- Latency: an enqueued instruction is visible at the head no earlier than the next cycle (`IQ_BYPASS_EN` off).
- Ordering: strict FIFO. No reordering and no partial flush.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro: `IQ_BYPASS_EN`.
- Defined:
  - When `count` == 0 and `if_valid` == 1, the head outputs are driven directly from the `if_*` inputs and `iq_valid` = 1 in the same cycle.
  - If `dp_ready` is also high (with `rdy_in` == 1 and no flush), the instruction is consumed without being written, and `head`, `tail` and `count` stay unchanged.
  - Otherwise it is enqueued as normal.
  - Gives zero-cycle latency on an empty queue.
- Undefined: the 1-cycle minimum latency above applies. No combinational path from `if_*` to `iq_*`.

Decomposition:
- Shared package (`riscv_pkg`) holds:
  - XLEN.
  - IQ_SIZE_BIT and DEPTH constants.
  - An `iq_entry` struct/typedef {inst, pc, pred_taken}, also used by the fetcher and the Dispatcher.
- Natural sub-module: `circular_fifo_ctrl`. It owns the head/tail/count logic and the full/almost_full flags, and is reusable by the RoB and LSB. The storage array stays in `instruction_queue`.

Test Plan:
- Reset hold: `rst_in` = 0 for 2 cycles with `if_valid` = 1 -> `iq_valid` = 0, `count` = 0, `iq_full` = 0. After release, `if_inst` = 0x00500093 at PC 0x0 appears at the head next cycle with `iq_pred_taken` = 0.
- Fill: 16 enqueues with `dp_ready` = 0 -> `iq_almost_full` rises after the 14th and `iq_full` after the 16th. A 17th `if_valid` is dropped; the 16 dequeued PCs are 0x0..0x3C in order.
- Wrap with simultaneous traffic: preload 15 entries, then 20 cycles of enq+deq -> `count` stays 15, pointers wrap, and every PC exits in order.
- Flush: 8 entries queued; assert `flush_signal` together with `if_valid` and `dp_ready` -> next cycle `iq_valid` = 0 and `count` = 0. The flushed-cycle enqueue is absent.
- Freeze: 3 entries queued, `rdy_in` = 0 for 5 cycles with `dp_ready` = 1 and `if_valid` = 1 -> `count` stays 3 and outputs are stable. Normal operation resumes after `rdy_in` returns to 1.
- Bypass (`IQ_BYPASS_EN` on): empty queue with `if_valid` = 1 and `dp_ready` = 1 -> `iq_valid` = 1 in the same cycle with `iq_pc` = `if_pc`, and `count` stays 0. With the macro off, `iq_valid` = 0 that cycle.
